// File: rtl/sc_mul_acc.sv
// ============================================================================
// sc_mul_acc : stochastic-computing multiplier with on-block ones-counter
// Revision   : 1.0
// ============================================================================
`default_nettype none

module sc_mul_acc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic             bipolar,
  output logic             busy,
  output logic             oC,
  output logic             oC_vld,
  output logic             done,
  output logic [WIDTH:0]   result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0] a_buf, b_buf, cnt, ra;
  logic [WIDTH:0]   acc, acc_nxt;
  logic             mode_buf;
  logic             accept, last, sa, sb;

  assign accept = start && ((state == IDLE) || (state == DONE));
  assign last   = (cnt == {WIDTH{1'b1}});

  // Bit-reversed count (van der Corput) for A, plain ramp for B: decorrelated streams.
  always_comb begin
    ra = '0;
    for (int i = 0; i < WIDTH; i++) ra[i] = cnt[WIDTH-1-i];
  end

  assign sa = (a_buf > ra);
  assign sb = (b_buf > cnt);
  assign oC = (state == RUN) && (mode_buf ? ~(sa ^ sb) : (sa & sb));

  assign acc_nxt = acc + {{WIDTH{1'b0}}, oC};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_buf    <= '0;
      b_buf    <= '0;
      mode_buf <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      result   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_buf    <= iA;
        b_buf    <= iB;
        mode_buf <= bipolar;
        cnt      <= '0;
        acc      <= '0;
      end else if (state == RUN) begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
        // Final bit folded in here; cnt wraps to 0 on the same edge.
        if (last) result <= acc_nxt;
      end
    end
  end

  assign busy   = (state == RUN);
  assign oC_vld = (state == RUN);
  assign done   = (state == DONE);

endmodule

`default_nettype wire
